// File: rtl/sqrt_sched_pkg.sv
// sqrt_sched_pkg: shared state type, width helper and default widths for the sqrt scheduler
package sqrt_sched_pkg;
  localparam int DW_DEF = 64;
  localparam int RW_DEF = DW_DEF / 2;
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sqrt_sched_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a combinational one-hot grant
// Ports: req (request vector), accept (advance pointer to the current winner),
//        grant (one-hot), grant_id (binary index of grant).
// The pointer resets to N-1 so requester 0 has first priority.
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = ID_W(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id
);
  logic [IW-1:0] last;
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    grant = '0;
    grant_id = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        grant_id = j;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= IW'(N - 1);
    else if (accept) last <= grant_id;
endmodule

// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin scheduler sharing one iterative sqrt engine among N_REQ requesters
// Ports: req_valid/req_data/req_ready  per-requester radicand handshake (ready only in IDLE)
//        resp_valid/resp_ready/resp_id/resp_root/resp_err  tagged result handshake
//        eng_start/eng_data/eng_done/eng_root/eng_abort    engine interface
// Macro SQRT_SCHED_TIMEOUT_EN adds a WAIT timeout that aborts the engine and returns resp_err.
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW = DW_DEF,
  parameter int RW = DW / 2,
  parameter int TIMEOUT = 255,
  localparam int IW = ID_W(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IW-1:0]       resp_id,
  output logic [RW-1:0]       resp_root,
  output logic                resp_err,
  output logic                eng_start,
  output logic [DW-1:0]       eng_data,
  input  logic                eng_done,
  input  logic [RW-1:0]       eng_root,
  output logic                eng_abort
);
  state_t state, state_n;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0] grant_id;
  logic accept, timed_out;
  assign accept = state == IDLE && |req_valid;
  // Gated by rst_n so no grant is offered while the block is held in reset.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign eng_start = state == START;
  assign resp_valid = state == RESP;
  assign eng_abort = state == WAIT && timed_out && !eng_done;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(req_valid),
    .accept(accept),
    .grant(grant),
    .grant_id(grant_id)
  );
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
  end
`ifdef SQRT_SCHED_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timed_out = wait_cnt == 8'(TIMEOUT);
  // Cleared in START so the first WAIT cycle sees zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (state == START) ? '0 : (state == WAIT) ? wait_cnt + 8'd1 : wait_cnt;
`else
  assign timed_out = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? START : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = (eng_done || timed_out) ? RESP : WAIT;
      RESP:    state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      eng_data <= '0;
      resp_id <= '0;
      resp_root <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        eng_data <= req_data[grant_id * DW +: DW];
        resp_id <= grant_id;
      end
      if (state == WAIT && (eng_done || timed_out)) begin
        resp_root <= eng_done ? eng_root : '0;
        resp_err <= !eng_done;
      end
    end
endmodule

// File: tb/tb_sqrt_sched.sv
// tb_sqrt_sched: directed and randomized checks of sqrt_sched against a round-robin/isqrt reference
module tb_sqrt_sched;
  localparam int N = 4, DW = 64, RW = 32, TO = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_ready;
  logic [N*DW-1:0] req_data;
  logic resp_valid, resp_ready, resp_err, eng_start, eng_done, eng_abort;
  logic [1:0] resp_id;
  logic [RW-1:0] resp_root, eng_root;
  logic [DW-1:0] eng_data;
  int vecs = 0, errs = 0;
  logic [DW-1:0] rad [N];
  logic [N-1:0] pend;
  int lg;

  always #5 clk = ~clk;

  sqrt_sched #(.N_REQ(N), .DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_root(resp_root), .resp_err(resp_err),
    .eng_start(eng_start), .eng_data(eng_data), .eng_done(eng_done),
    .eng_root(eng_root), .eng_abort(eng_abort)
  );

  function automatic logic [RW-1:0] isqrt(input logic [DW-1:0] x);
    logic [64:0] lo, hi, mid;
    lo = '0;
    hi = 65'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 65'd1) >> 1;
      if (mid * mid <= {1'b0, x}) lo = mid;
      else hi = mid - 65'd1;
    end
    return lo[RW-1:0];
  endfunction

  function automatic int pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++)
      if (p[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rad[i];
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    rad[i] = {$urandom, $urandom} >> $urandom_range(0, 63);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_id"}, resp_id, 0);
    chk({tag, "_resp_root"}, resp_root, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_data"}, eng_data, 0);
    chk({tag, "_eng_abort"}, eng_abort, 0);
  endtask

  // One full transaction starting from an IDLE cycle; refill: 0 none, 1 re-request winner, 2 random.
  task automatic txn(input int lat, input int stall, input int refill, input bit early);
    int g;
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    @(negedge clk);
    resp_ready = 1'b0;
    eng_done = 1'b0;
    if (pend == 0) new_req($urandom_range(0, N - 1));
    drive();
    #1;
    g = pick(pend, lg);
    d = rad[g];
    r = isqrt(d);
    chk("idle_resp_valid", resp_valid, 0);
    chk("grant", req_ready, 64'(1) << g);
    @(negedge clk);
    lg = g;
    pend[g] = 1'b0;
    if (refill == 1) new_req(g);
    if (refill == 2)
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i);
    drive();
    eng_done = early;
    eng_root = ~r;
    #1;
    chk("start", eng_start, 1);
    chk("eng_data", eng_data, d);
    chk("ready_busy", req_ready, 0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      eng_done = (c == lat);
      eng_root = (c == lat) ? r : RW'($urandom);
      #1;
      chk("no_start", eng_start, 0);
      chk("hold_data", eng_data, d);
      chk("wait_resp", resp_valid, 0);
      chk("wait_abort", eng_abort, 0);
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      resp_ready = (s == stall);
      eng_done = 1'($urandom_range(0, 1));
      eng_root = RW'($urandom);
      #1;
      chk("resp_valid", resp_valid, 1);
      chk("resp_id", resp_id, g);
      chk("resp_root", resp_root, r);
      chk("resp_err", resp_err, 0);
      chk("resp_ready_zero", req_ready, 0);
      chk("resp_no_start", eng_start, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pend = '0;
    for (int i = 0; i < N; i++) rad[i] = '0;
    drive();
    resp_ready = 1'b0;
    eng_done = 1'b0;
    eng_root = '0;
    lg = N - 1;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    pend = 4'b0001;
    rad[0] = 64'd64;
    txn(5, 0, 0, 1'b0);

    pend = 4'b0100;
    new_req(2);
    txn(3, 10, 0, 1'b1);

    pend = '0;
    rad[3] = 64'h3FFF_FFFF_0000_0001;
    pend[3] = 1'b1;
    txn(4, 0, 0, 1'b0);

    for (int i = 0; i < N; i++) new_req(i);
    repeat (5) txn(2, 0, 1, 1'b0);

    repeat (40) txn($urandom_range(1, 6), $urandom_range(0, 3), 2, 1'($urandom_range(0, 1)));

    @(negedge clk);
    resp_ready = 1'b0;
    eng_done = 1'b0;
    pend = '0;
    new_req(1);
    drive();
    #1;
    chk("pre_rst_grant", req_ready, 4'b0010);
    @(negedge clk);
    pend = '0;
    drive();
    #1;
    chk("pre_rst_start", eng_start, 1);
`ifdef SQRT_SCHED_TIMEOUT_EN
    repeat (5) begin
`else
    repeat (40) begin
`endif
      @(negedge clk);
      #1;
      chk("stuck_resp", resp_valid, 0);
      chk("stuck_abort", eng_abort, 0);
    end
    @(negedge clk);
    pend = 4'b0101;
    rad[0] = 64'd1000000;
    rad[2] = 64'd99;
    drive();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    #1;
    chk_reset_outputs("hold_rst");
    pend = '0;
    drive();
    rst_n = 1'b1;
    lg = N - 1;
    pend = 4'b0101;
    txn(2, 0, 0, 1'b0);
    txn(1, 1, 0, 1'b0);

`ifdef SQRT_SCHED_TIMEOUT_EN
    @(negedge clk);
    resp_ready = 1'b0;
    eng_done = 1'b0;
    pend = '0;
    new_req(3);
    drive();
    #1;
    chk("to_grant", req_ready, 64'(1) << pick(pend, lg));
    @(negedge clk);
    lg = 3;
    pend = '0;
    drive();
    #1;
    chk("to_start", eng_start, 1);
    for (int c = 1; c <= TO + 1; c++) begin
      @(negedge clk);
      #1;
      chk("to_abort", eng_abort, c == TO + 1);
      chk("to_wait_resp", resp_valid, 0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_root", resp_root, 0);
    chk("to_resp_id", resp_id, 3);
    chk("to_abort_once", eng_abort, 0);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("to_idle", resp_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
